prbs_gen: RTL and testbench

PRBS_GEN -- requirements
Module: prbs_gen

---
 rtl/prbs_gen.sv | 130 +++++++++++++
 tb/tb_prbs_gen.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_gen.sv
// Fibonacci LFSR PRBS generator with seed load, enable gating and an optional
// SEQ_LEN-bit burst mode. Define PRBS_CHECK_EN to add a self-synchronising checker.
module prbs_gen #(
    parameter int               WIDTH   = 7,
    parameter logic [WIDTH-1:0] TAPS    = 7'b1100000,
    parameter int               SEQ_LEN = 127
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             enable,
    output logic             q,
    output logic             valid_out,
    output logic             done,
    output logic [WIDTH-1:0] lfsr_state
`ifdef PRBS_CHECK_EN
    ,
    input  logic             rx_bit,
    input  logic             rx_valid,
    output logic [15:0]      err_count,
    output logic             locked
`endif
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam int               CNT_W  = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam int               LAST_I = (SEQ_LEN > 0) ? SEQ_LEN - 1 : 0;
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(LAST_I);

    logic [0:0]       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] tap_bits;
    logic [WIDTH-1:0] seed_fix;
    logic             fb;
    logic             shift_ok;
    logic             last_bit;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_tap
            assign tap_bits[gi] = lfsr_state[gi] & TAPS[gi];
        end
    endgenerate

    assign fb       = ^tap_bits;
    assign shift_ok = (state_reg == RUN) && enable;
    assign last_bit = (SEQ_LEN != 0) && (cnt_reg == LAST);
    // An all-zero seed would lock the LFSR at zero forever.
    assign seed_fix = (seed == '0) ? '1 : seed;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            lfsr_state <= '1;
            q          <= 1'b0;
            valid_out  <= 1'b0;
            done       <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            done      <= 1'b0;
            if (load) begin
                // A load landing on the final bit still lets that bit out with done.
                if (shift_ok && last_bit) begin
                    q         <= lfsr_state[WIDTH-1];
                    valid_out <= 1'b1;
                    done      <= 1'b1;
                end
                lfsr_state <= seed_fix;
                cnt_reg    <= '0;
                state_reg  <= RUN;
            end else if (shift_ok) begin
                q          <= lfsr_state[WIDTH-1];
                lfsr_state <= {lfsr_state[WIDTH-2:0], fb};
                valid_out  <= 1'b1;
                if (last_bit) begin
                    done      <= 1'b1;
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end
    end

`ifdef PRBS_CHECK_EN
    localparam int               FILL_W    = $clog2(WIDTH);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(WIDTH - 1);

    logic [WIDTH-1:0]  rx_sr_reg;
    logic [WIDTH-1:0]  rx_tap_bits;
    logic [FILL_W-1:0] fill_reg;
    logic              rx_fb;

    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_rx_tap
            assign rx_tap_bits[gi] = rx_sr_reg[gi] & TAPS[gi];
        end
    endgenerate

    // Once full, the receive register equals the sender's LFSR WIDTH bits ago,
    // so its feedback predicts the next incoming bit.
    assign rx_fb = ^rx_tap_bits;

    always_ff @(posedge clk) begin
        if (!reset || load) begin
            rx_sr_reg <= '0;
            fill_reg  <= '0;
            locked    <= 1'b0;
            err_count <= '0;
        end else if (rx_valid) begin
            rx_sr_reg <= {rx_sr_reg[WIDTH-2:0], rx_bit};
            if (!locked) begin
                if (fill_reg == FILL_LAST) begin
                    locked <= 1'b1;
                end else begin
                    fill_reg <= fill_reg + FILL_W'(1);
                end
            end else if ((rx_bit != rx_fb) && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_prbs_gen.sv
// Self-checking bench for prbs_gen: scoreboard of expected outputs for the default
// PRBS7 instance, plus a 5-bit free-running instance checked for its 31-bit period.
module tb_prbs_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load = 1'b0;
    logic [6:0] seed = '0;
    logic       enable = 1'b0;
    logic       q, valid_out, done;
    logic [6:0] lfsr_state;

    logic       load2 = 1'b0;
    logic [4:0] seed2 = '0;
    logic       enable2 = 1'b0;
    logic       q2, valid2, done2;
    logic [4:0] lfsr2;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [6:0] TAPS_M = 7'b1100000;

`ifdef PRBS_CHECK_EN
    logic        inj = 1'b0;
    logic        rx_bit, rx_valid, locked;
    logic [15:0] err_count;
    logic        locked2;
    logic [15:0] err_count2;
    assign rx_bit   = q ^ inj;
    assign rx_valid = valid_out;
`endif

    always #5 clk = ~clk;

    prbs_gen u_dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .seed       (seed),
        .enable     (enable),
        .q          (q),
        .valid_out  (valid_out),
        .done       (done),
        .lfsr_state (lfsr_state)
`ifdef PRBS_CHECK_EN
        ,
        .rx_bit     (rx_bit),
        .rx_valid   (rx_valid),
        .err_count  (err_count),
        .locked     (locked)
`endif
    );

    prbs_gen #(.WIDTH(5), .TAPS(5'b10100), .SEQ_LEN(0)) u_free (
        .clk        (clk),
        .reset      (reset),
        .load       (load2),
        .seed       (seed2),
        .enable     (enable2),
        .q          (q2),
        .valid_out  (valid2),
        .done       (done2),
        .lfsr_state (lfsr2)
`ifdef PRBS_CHECK_EN
        ,
        .rx_bit     (1'b0),
        .rx_valid   (1'b0),
        .err_count  (err_count2),
        .locked     (locked2)
`endif
    );

    typedef struct packed {
        logic       valid;
        logic       q;
        logic       done;
        logic [6:0] lfsr;
    } exp_t;

    exp_t sb[$];

    logic       m_run = 1'b0;
    logic [6:0] m_lfsr = '1;
    logic       m_q = 1'b0;
    int         m_cnt = 0;

    function automatic logic [6:0] next_lfsr(input logic [6:0] s);
        logic f;
        f = 1'b0;
        for (int i = 0; i < 7; i++) f = f ^ (s[i] & TAPS_M[i]);
        return {s[5:0], f};
    endfunction

    // Drive one cycle of stimulus, push the expected post-edge outputs, advance.
    task automatic drive(input logic rst_n, input logic ld, input logic [6:0] sd, input logic en);
        exp_t e;
        logic fin;
        reset  = rst_n;
        load   = ld;
        seed   = sd;
        enable = en;
        e.valid = 1'b0;
        e.done  = 1'b0;
        if (!rst_n) begin
            m_run = 1'b0; m_lfsr = '1; m_q = 1'b0; m_cnt = 0;
        end else begin
            fin = m_run && en && (m_cnt == 126);
            if (ld) begin
                if (fin) begin
                    m_q = m_lfsr[6]; e.valid = 1'b1; e.done = 1'b1;
                end
                m_lfsr = (sd == 7'd0) ? 7'h7F : sd;
                m_cnt  = 0;
                m_run  = 1'b1;
            end else if (m_run && en) begin
                m_q     = m_lfsr[6];
                m_lfsr  = next_lfsr(m_lfsr);
                e.valid = 1'b1;
                m_cnt++;
                if (m_cnt == 127) begin
                    e.done = 1'b1; m_run = 1'b0; m_cnt = 0;
                end
            end
        end
        e.q    = m_q;
        e.lfsr = m_lfsr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        reset = 1'b1;
        load  = 1'b0;
    endtask

    task automatic test_reset;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            drive((i < 2) ? 1'b0 : 1'b1, (i < 2) ? 1'b1 : 1'b0, 7'h55, 1'b1);
            e = sb.pop_front();
            n_vec++;
            if (valid_out !== e.valid || q !== e.q || done !== e.done || lfsr_state !== e.lfsr) begin
                n_err++;
                $display("FAIL reset[%0d]: got v=%b q=%b d=%b s=%b, want v=%b q=%b d=%b s=%b",
                         i, valid_out, q, done, lfsr_state, e.valid, e.q, e.done, e.lfsr);
            end
        end
        n_vec++;
        if (lfsr_state !== 7'h7F || q !== 1'b0 || valid_out !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: got s=%b q=%b v=%b, want s=1111111 q=0 v=0", lfsr_state, q, valid_out);
        end
    endtask

    task automatic test_basic;
        exp_t e;
        int nvalid = 0;
        int done_at = -1;
        logic [2:0] first = 3'b101;
        drive(1'b1, 1'b1, 7'b1010101, 1'b0);
        e = sb.pop_front();
        n_vec++;
        if (valid_out !== e.valid || lfsr_state !== e.lfsr) begin
            n_err++;
            $display("FAIL basic_load: got v=%b s=%b, want v=%b s=%b", valid_out, lfsr_state, e.valid, e.lfsr);
        end
        for (int i = 0; i < 128; i++) begin
            drive(1'b1, 1'b0, 7'd0, 1'b1);
            e = sb.pop_front();
            n_vec++;
            if (valid_out !== e.valid || q !== e.q || done !== e.done || lfsr_state !== e.lfsr) begin
                n_err++;
                $display("FAIL basic[%0d]: got v=%b q=%b d=%b s=%b, want v=%b q=%b d=%b s=%b",
                         i, valid_out, q, done, lfsr_state, e.valid, e.q, e.done, e.lfsr);
            end
            if (i < 3) begin
                n_vec++;
                if (q !== first[2-i]) begin
                    n_err++;
                    $display("FAIL basic_first_bit[%0d]: got %b, want %b", i, q, first[2-i]);
                end
            end
            if (i == 126) begin
                n_vec++;
                if (lfsr_state !== 7'b1010101) begin
                    n_err++;
                    $display("FAIL basic_wrap: got s=%b, want 1010101", lfsr_state);
                end
            end
            if (valid_out === 1'b1) nvalid++;
            if (done === 1'b1) done_at = i;
        end
        n_vec++;
        if (nvalid != 127 || done_at != 126) begin
            n_err++;
            $display("FAIL basic_count: got valids=%0d done_at=%0d, want 127 and 126", nvalid, done_at);
        end
    endtask

    task automatic test_zero_seed;
        exp_t e;
        int nvalid = 0;
        int ndone = 0;
        drive(1'b1, 1'b1, 7'd0, 1'b0);
        e = sb.pop_front();
        n_vec++;
        if (lfsr_state !== 7'b1111111 || lfsr_state !== e.lfsr) begin
            n_err++;
            $display("FAIL zero_seed_load: got s=%b, want 1111111", lfsr_state);
        end
        for (int i = 0; i < 130; i++) begin
            drive(1'b1, 1'b0, 7'd0, 1'b1);
            e = sb.pop_front();
            n_vec++;
            if (valid_out !== e.valid || q !== e.q || done !== e.done || lfsr_state !== e.lfsr) begin
                n_err++;
                $display("FAIL zero_seed[%0d]: got v=%b q=%b d=%b s=%b, want v=%b q=%b d=%b s=%b",
                         i, valid_out, q, done, lfsr_state, e.valid, e.q, e.done, e.lfsr);
            end
            if (valid_out === 1'b1) nvalid++;
            if (done === 1'b1) ndone++;
        end
        n_vec++;
        if (nvalid != 127 || ndone != 1) begin
            n_err++;
            $display("FAIL zero_seed_count: got valids=%0d dones=%0d, want 127 and 1", nvalid, ndone);
        end
    endtask

    task automatic test_enable_gap;
        exp_t e;
        int nvalid = 0;
        int ndone = 0;
        logic [3:0] pat = 4'b1001;
        drive(1'b1, 1'b1, 7'h3C, 1'b0);
        e = sb.pop_front();
        for (int i = 0; i < 600 && ndone == 0; i++) begin
            drive(1'b1, 1'b0, 7'd0, pat[3 - (i % 4)]);
            e = sb.pop_front();
            n_vec++;
            if (valid_out !== e.valid || q !== e.q || done !== e.done || lfsr_state !== e.lfsr) begin
                n_err++;
                $display("FAIL enable_gap[%0d]: got v=%b q=%b d=%b s=%b, want v=%b q=%b d=%b s=%b",
                         i, valid_out, q, done, lfsr_state, e.valid, e.q, e.done, e.lfsr);
            end
            if (valid_out === 1'b1) nvalid++;
            if (done === 1'b1) ndone++;
        end
        n_vec++;
        if (nvalid != 127 || ndone != 1) begin
            n_err++;
            $display("FAIL enable_gap_count: got valids=%0d dones=%0d, want 127 and 1", nvalid, ndone);
        end
    endtask

    task automatic test_reset_mid;
        exp_t e;
        int nact = 0;
        drive(1'b1, 1'b1, 7'h2A, 1'b1);
        e = sb.pop_front();
        for (int i = 0; i < 50; i++) begin
            drive(1'b1, 1'b0, 7'd0, 1'b1);
            e = sb.pop_front();
        end
        drive(1'b0, 1'b0, 7'd0, 1'b1);
        e = sb.pop_front();
        n_vec++;
        if (valid_out !== 1'b0 || done !== 1'b0 || lfsr_state !== 7'h7F || lfsr_state !== e.lfsr) begin
            n_err++;
            $display("FAIL reset_mid: got v=%b d=%b s=%b, want v=0 d=0 s=1111111", valid_out, done, lfsr_state);
        end
        for (int i = 0; i < 130; i++) begin
            drive(1'b1, 1'b0, 7'd0, 1'b1);
            e = sb.pop_front();
            if (valid_out !== 1'b0 || done !== 1'b0) nact++;
        end
        n_vec++;
        if (nact != 0) begin
            n_err++;
            $display("FAIL reset_mid_idle: got %0d active cycles after abort, want 0", nact);
        end
    endtask

    task automatic test_load_final;
        exp_t e;
        int ndone = 0;
        drive(1'b1, 1'b1, 7'h11, 1'b1);
        e = sb.pop_front();
        for (int i = 0; i < 126; i++) begin
            drive(1'b1, 1'b0, 7'd0, 1'b1);
            e = sb.pop_front();
        end
        drive(1'b1, 1'b1, 7'h33, 1'b1);
        e = sb.pop_front();
        n_vec++;
        if (valid_out !== 1'b1 || done !== 1'b1 || lfsr_state !== 7'h33 || q !== e.q) begin
            n_err++;
            $display("FAIL load_final: got v=%b d=%b s=%b q=%b, want v=1 d=1 s=0110011 q=%b",
                     valid_out, done, lfsr_state, q, e.q);
        end
        for (int i = 0; i < 127; i++) begin
            drive(1'b1, 1'b0, 7'd0, 1'b1);
            e = sb.pop_front();
            n_vec++;
            if (valid_out !== e.valid || q !== e.q || done !== e.done || lfsr_state !== e.lfsr) begin
                n_err++;
                $display("FAIL load_final_run[%0d]: got v=%b q=%b d=%b s=%b, want v=%b q=%b d=%b s=%b",
                         i, valid_out, q, done, lfsr_state, e.valid, e.q, e.done, e.lfsr);
            end
            if (done === 1'b1) ndone++;
        end
        n_vec++;
        if (ndone != 1 || done !== 1'b1) begin
            n_err++;
            $display("FAIL load_final_restart: got dones=%0d last_done=%b, want 1 and 1", ndone, done);
        end
    endtask

    task automatic test_free_run;
        logic qs [100];
        int returns = 0;
        int first_ret = -1;
        int bad = 0;
        int pmis = 0;
        enable  = 1'b0;
        load2   = 1'b1;
        seed2   = 5'b00001;
        enable2 = 1'b1;
        @(posedge clk);
        #1;
        load2 = 1'b0;
        n_vec++;
        if (lfsr2 !== 5'b00001 || valid2 !== 1'b0) begin
            n_err++;
            $display("FAIL free_load: got s=%b v=%b, want s=00001 v=0", lfsr2, valid2);
        end
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            qs[i] = q2;
            if (valid2 !== 1'b1 || done2 !== 1'b0) bad++;
            if (lfsr2 === 5'b00001) begin
                returns++;
                if (first_ret < 0) first_ret = i + 1;
            end
        end
        enable2 = 1'b0;
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL free_valid_done: got %0d bad cycles, want 0", bad);
        end
        n_vec++;
        if (first_ret != 31 || returns != 3) begin
            n_err++;
            $display("FAIL free_period: got first_return=%0d returns=%0d, want 31 and 3", first_ret, returns);
        end
        for (int i = 0; i < 69; i++) if (qs[i] !== qs[i+31]) pmis++;
        n_vec++;
        if (pmis != 0) begin
            n_err++;
            $display("FAIL free_bit_period: got %0d bit differences at lag 31, want 0", pmis);
        end
    endtask

`ifdef PRBS_CHECK_EN
    task automatic test_checker;
        exp_t e;
        logic [15:0] err_hold;
        drive(1'b1, 1'b1, 7'h5A, 1'b0);
        e = sb.pop_front();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 7'd0, 1'b1);
            e = sb.pop_front();
        end
        n_vec++;
        if (locked !== 1'b0) begin
            n_err++;
            $display("FAIL chk_early_lock: got locked=%b, want 0", locked);
        end
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 1'b0, 7'd0, 1'b1);
            e = sb.pop_front();
        end
        n_vec++;
        if (locked !== 1'b1 || err_count !== 16'd0) begin
            n_err++;
            $display("FAIL chk_lock: got locked=%b err=%0d, want 1 and 0", locked, err_count);
        end
        inj = 1'b1;
        drive(1'b1, 1'b0, 7'd0, 1'b1);
        e = sb.pop_front();
        inj = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, 7'd0, 1'b1);
            e = sb.pop_front();
        end
        err_hold = err_count;
        n_vec++;
        if (err_count == 16'd0 || err_count > 16'd7) begin
            n_err++;
            $display("FAIL chk_err: got err=%0d, want 1..7", err_count);
        end
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, 7'd0, 1'b1);
            e = sb.pop_front();
        end
        n_vec++;
        if (err_count !== err_hold) begin
            n_err++;
            $display("FAIL chk_stable: got err=%0d, want %0d", err_count, err_hold);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_zero_seed;
        test_enable_gap;
        test_reset_mid;
        test_load_final;
        test_free_run;
`ifdef PRBS_CHECK_EN
        test_checker;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
